cache_miss_ctrl: RTL and testbench
==================================

# cache_miss_ctrl

Miss-side controller for the 2-way set-associative L1 cache; the write side of the tag/valid/dirty arrays whose read side feeds the per-way hit detector. It consumes `hit0`/`hit1` and per-set metadata, owns the per-set LRU bits, and services misses. On a miss it writes back a dirty victim to physical memory, fills the line, and updates tag/valid/dirty. It sits between the CPU memory port and the physical-memory port, and drives datapath load enables and mux selects.

## Interface
- `TAG_W`, 9, tag width (address[15:7])
- `IDX_W`, 3, set index width (address[6:4]); offset is address[3:0], 16-byte line
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `mem_read`, `mem_write`  in  1  CPU request strobes, held until `mem_resp`
- `mem_address`  in  16  CPU byte address
- `hit0`, `hit1`  in  1  way hit flags for the current address, at most one high
- `valid0`, `valid1`, `dirty0`, `dirty1`  in  1  metadata of the indexed set
- `tag0`, `tag1`  in  TAG_W  stored tags of the indexed set
- `mem_resp`  out  1  one-cycle CPU completion
- `way_sel`  out  1  datapath read/write way (hit way, else latched victim)
- `data_load0`, `data_load1`  out  1  line-data write enable per way
- `fill_sel`  out  1  1 = line data comes from `pmem_rdata`, 0 = CPU merge
- `meta_load0`, `meta_load1`  out  1  tag/valid/dirty write enable per way
- `valid_in`, `dirty_in`  out  1  metadata write values
- `pmem_read`, `pmem_write`  out  1  physical-memory strobes, held until `pmem_resp`
- `pmem_address`  out  16  line-aligned physical address, [3:0] = 0
- `pmem_resp`  in  1  physical-memory completion, one cycle
- `miss_count`, `wb_count`  out  16  performance counters

## Operation
- Internal state: `lru[2**IDX_W]` (1 = way 1 is LRU), `victim` register, FSM `state`, two counters.
- IDLE:
  - Hit on either flag with a request pending:
    - `mem_resp`=1 and `way_sel`=hit way, in the same cycle.
    - `lru[idx]` set to the non-hit way.
    - Write hit: `data_load`/`meta_load` of the hit way, `fill_sel`=0, `valid_in`=1, `dirty_in`=1.
  - Request with no hit:
    - latch `victim <= lru[idx]` and increment `miss_count`.
    - Go to WRITEBACK if the victim is valid and dirty (increment `wb_count`), else FILL.
- WRITEBACK:
  - `pmem_write`=1, `way_sel`=victim, `pmem_address`={victim tag, idx, 4'h0}.
  - On `pmem_resp` go to FILL.
- FILL:
  - `pmem_read`=1, `pmem_address`={mem_address[15:4], 4'h0}.
  - On `pmem_resp`: `data_load`+`meta_load` of the victim, `fill_sel`=1, `valid_in`=1, `dirty_in`=0. Go to IDLE.
- Back in IDLE the request re-evaluates as a hit and completes through the hit path. Only that path asserts `mem_resp` and updates LRU.
- The victim is fixed once latched. LRU does not change during WRITEBACK or FILL.
- Counters are 16-bit and wrap 0xFFFF→0x0000.
- Request dropped by the CPU mid-miss (not legal): the FSM completes the line transaction anyway; no `mem_resp` if the request is no longer present in IDLE.
- `mem_read` and `mem_write` both high: treated as a write.

## Timing
- Reset (`rst_n`=0 at a clock edge) clears `state`, all `lru` bits, `victim`, and both counters to 0.
- Outputs are combinational from state and inputs: 0 during reset and in IDLE with no request.
- Reset mid-WRITEBACK/FILL: the FSM is in IDLE the next cycle and the `pmem_*` strobes drop in that cycle. Any following `pmem_resp` is ignored.
- Hit latency: 0 cycles; `mem_resp` in the request cycle.
- Clean-miss latency: 1 (IDLE) + N_fill + 1 (hit cycle) cycles, where N_fill counts from the first FILL cycle to `pmem_resp` inclusive.
- Dirty miss: add N_wb for the WRITEBACK phase.
- `pmem_read` and `pmem_write` are never high together. Each is held continuously until `pmem_resp`.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0 for 2 cycles during FILL.
  - Response: next cycle `pmem_read`=0, counters 0, all LRU bits 0.
- Read hit:
  - Stimulus: `mem_read` to 0x1234 with `hit1`=1.
  - Response: `mem_resp` same cycle, `way_sel`=1, `lru[3]`=0, no `pmem_*` activity.
- Clean read miss:
  - Stimulus: `mem_read` 0x1234, no hit, `lru[3]`=0, way 0 invalid, `pmem_resp` after 3 cycles.
  - Response: `pmem_read` with `pmem_address`=0x1230 for 3 cycles; on `pmem_resp`, `data_load0`=`meta_load0`=1, `fill_sel`=1, `dirty_in`=0; `miss_count`=1.
- Dirty miss:
  - Stimulus: victim way 1 with `tag1`=0x0AB, dirty, set 3.
  - Response: `pmem_write` at 0x55B0 until `pmem_resp`, then `pmem_read` at 0x1230; `wb_count`=1.
- Write hit:
  - Stimulus: `mem_write` with `hit0`=1.
  - Response: `data_load0`=1, `meta_load0`=1, `dirty_in`=1, `mem_resp`=1 in the same cycle.
- Counter wrap:
  - Stimulus: force 65536 misses.
  - Response: `miss_count` returns to 0x0000.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss-side controller for a 2-way set-associative L1 cache: completes hits in IDLE,
// and services misses with an optional dirty-victim writeback followed by a line fill.
module cache_miss_ctrl #(
    parameter int TAG_W = 9,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_address,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    output logic             mem_resp,
    output logic             way_sel,
    output logic             data_load0,
    output logic             data_load1,
    output logic             fill_sel,
    output logic             meta_load0,
    output logic             meta_load1,
    output logic             valid_in,
    output logic             dirty_in,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    input  logic             pmem_resp,
    output logic [15:0]      miss_count,
    output logic [15:0]      wb_count
);

    localparam int SETS = 2**IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic              victim_q, victim_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
    logic [15:0]       wb_cnt_q, wb_cnt_d;

    logic [IDX_W-1:0]  idx_s;
    logic              req_s;
    logic              hit_s;
    logic              lru_way_s;
    logic              victim_dirty_s;
    logic [TAG_W-1:0]  victim_tag_s;
    logic              unused_s;

    assign idx_s          = mem_address[4 +: IDX_W];
    assign req_s          = mem_read | mem_write;
    assign hit_s          = hit0 | hit1;
    assign lru_way_s      = lru_q[idx_s];
    assign victim_dirty_s = lru_way_s ? (valid1 & dirty1) : (valid0 & dirty0);
    assign victim_tag_s   = victim_q ? tag1 : tag0;
    assign unused_s       = ^mem_address[3:0];

    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

    // State register together with LRU bits, victim latch and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            miss_cnt_q <= 16'h0000;
            wb_cnt_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            lru_q      <= lru_d;
            victim_q   <= victim_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    // Next-state logic; LRU only moves on a completed hit, the victim only on a new miss.
    always_comb begin
        state_d    = state_q;
        lru_d      = lru_q;
        victim_d   = victim_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && hit_s) begin
                    lru_d[idx_s] = ~hit1;
                end else if (req_s) begin
                    victim_d   = lru_way_s;
                    miss_cnt_d = miss_cnt_q + 16'd1;
                    if (victim_dirty_s) begin
                        wb_cnt_d = wb_cnt_q + 16'd1;
                        state_d  = ST_WB;
                    end else begin
                        state_d  = ST_FILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (pmem_resp) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_FILL: begin
                if (pmem_resp) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        mem_resp     = 1'b0;
        way_sel      = 1'b0;
        data_load0   = 1'b0;
        data_load1   = 1'b0;
        fill_sel     = 1'b0;
        meta_load0   = 1'b0;
        meta_load1   = 1'b0;
        valid_in     = 1'b0;
        dirty_in     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s && hit_s) begin
                        mem_resp = 1'b1;
                        way_sel  = hit1;
                        if (mem_write) begin
                            data_load0 = ~hit1;
                            data_load1 = hit1;
                            meta_load0 = ~hit1;
                            meta_load1 = hit1;
                            valid_in   = 1'b1;
                            dirty_in   = 1'b1;
                        end else begin
                            fill_sel = 1'b0;
                        end
                    end else if (req_s) begin
                        way_sel = victim_q;
                    end else begin
                        way_sel = 1'b0;
                    end
                end
                ST_WB: begin
                    pmem_write   = 1'b1;
                    way_sel      = victim_q;
                    pmem_address = {victim_tag_s, idx_s, 4'h0};
                end
                ST_FILL: begin
                    pmem_read    = 1'b1;
                    way_sel      = victim_q;
                    pmem_address = {mem_address[15:4], 4'h0};
                    if (pmem_resp) begin
                        data_load0 = ~victim_q;
                        data_load1 = victim_q;
                        meta_load0 = ~victim_q;
                        meta_load1 = victim_q;
                        fill_sel   = 1'b1;
                        valid_in   = 1'b1;
                        dirty_in   = 1'b0;
                    end else begin
                        fill_sel = 1'b0;
                    end
                end
                default: begin
                    way_sel = 1'b0;
                end
            endcase
        end else begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: directed stimulus pushes per-cycle expected
// observations; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic        hit0, hit1, valid0, valid1, dirty0, dirty1;
    logic [8:0]  tag0, tag1;
    logic        mem_resp, way_sel, data_load0, data_load1, fill_sel;
    logic        meta_load0, meta_load1, valid_in, dirty_in;
    logic        pmem_read, pmem_write;
    logic [15:0] pmem_address;
    logic        pmem_resp;
    logic [15:0] miss_count, wb_count;

    cache_miss_ctrl #(.TAG_W(9), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .tag0(tag0), .tag1(tag1),
        .mem_resp(mem_resp), .way_sel(way_sel),
        .data_load0(data_load0), .data_load1(data_load1), .fill_sel(fill_sel),
        .meta_load0(meta_load0), .meta_load1(meta_load1),
        .valid_in(valid_in), .dirty_in(dirty_in),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_resp(pmem_resp), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        resp, ws, dl0, dl1, ml0, ml1, fs, vi, di, pr, pw;
        logic [15:0] addr, miss, wb;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;
    logic  probe  = 1'b0;
    obs_t  act_o, exp_o;
    string nm;

    function automatic obs_t e_zero(input logic [15:0] m, input logic [15:0] w);
        obs_t o = '0;
        o.miss = m; o.wb = w;
        return o;
    endfunction

    function automatic obs_t e_hit(input logic way, input logic wr, input logic [15:0] m, input logic [15:0] w);
        obs_t o = '0;
        o.resp = 1'b1; o.ws = way;
        if (wr) begin
            o.dl0 = ~way; o.dl1 = way; o.ml0 = ~way; o.ml1 = way;
            o.vi = 1'b1; o.di = 1'b1;
        end
        o.miss = m; o.wb = w;
        return o;
    endfunction

    function automatic obs_t e_wb(input logic way, input logic [15:0] a, input logic [15:0] m, input logic [15:0] w);
        obs_t o = '0;
        o.pw = 1'b1; o.ws = way; o.addr = a; o.miss = m; o.wb = w;
        return o;
    endfunction

    function automatic obs_t e_fill(input logic way, input logic [15:0] a, input logic last,
                                    input logic [15:0] m, input logic [15:0] w);
        obs_t o = '0;
        o.pr = 1'b1; o.ws = way; o.addr = a; o.miss = m; o.wb = w;
        if (last) begin
            o.dl0 = ~way; o.dl1 = way; o.ml0 = ~way; o.ml1 = way;
            o.fs = 1'b1; o.vi = 1'b1; o.di = 1'b0;
        end
        return o;
    endfunction

    task automatic expect_obs(input string n, input obs_t o);
        exp_q.push_back(o);
        name_q.push_back(n);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0; pmem_resp = 1'b0;
    endtask

    // Monitor: compare the oldest expectation on every active or probed cycle.
    always @(negedge clk) begin
        if (probe || mem_resp || pmem_read || pmem_write || data_load0 || data_load1 ||
            meta_load0 || meta_load1) begin
            act_o = '0;
            act_o.resp = mem_resp;   act_o.ws = way_sel;
            act_o.dl0 = data_load0;  act_o.dl1 = data_load1;
            act_o.ml0 = meta_load0;  act_o.ml1 = meta_load1;
            act_o.fs = fill_sel;     act_o.vi = valid_in;   act_o.di = dirty_in;
            act_o.pr = pmem_read;    act_o.pw = pmem_write;
            act_o.addr = pmem_address; act_o.miss = miss_count; act_o.wb = wb_count;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got resp=%b ws=%b pr=%b pw=%b addr=%h miss=%h wb=%h, none expected",
                         act_o.resp, act_o.ws, act_o.pr, act_o.pw, act_o.addr, act_o.miss, act_o.wb);
            end else begin
                exp_o = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_o === exp_o) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got resp=%b ws=%b ld=%b%b ml=%b%b fs=%b vi=%b di=%b pr=%b pw=%b addr=%h miss=%h wb=%h; want resp=%b ws=%b ld=%b%b ml=%b%b fs=%b vi=%b di=%b pr=%b pw=%b addr=%h miss=%h wb=%h",
                             nm, act_o.resp, act_o.ws, act_o.dl0, act_o.dl1, act_o.ml0, act_o.ml1,
                             act_o.fs, act_o.vi, act_o.di, act_o.pr, act_o.pw, act_o.addr, act_o.miss, act_o.wb,
                             exp_o.resp, exp_o.ws, exp_o.dl0, exp_o.dl1, exp_o.ml0, exp_o.ml1,
                             exp_o.fs, exp_o.vi, exp_o.di, exp_o.pr, exp_o.pw, exp_o.addr, exp_o.miss, exp_o.wb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0000;
        hit0 = 1'b0; hit1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0;
        tag0 = 9'h000; tag1 = 9'h000; pmem_resp = 1'b0;

        cyc();
        cyc(); probe = 1'b1; expect_obs("reset_outputs", e_zero(16'h0000, 16'h0000));
        cyc(); probe = 1'b0; rst_n = 1'b1;

        // Read hit on way 1, set 3: LRU[3] becomes 0.
        cyc(); mem_read = 1'b1; mem_address = 16'h1234; hit1 = 1'b1;
        expect_obs("read_hit", e_hit(1'b1, 1'b0, 16'h0000, 16'h0000));
        cyc(); drop_req();

        // Clean miss: victim way 0 (invalid), three FILL cycles.
        cyc(); mem_read = 1'b1; valid0 = 1'b0; valid1 = 1'b1; dirty1 = 1'b0;
        cyc(); expect_obs("clean_fill_1", e_fill(1'b0, 16'h1230, 1'b0, 16'h0001, 16'h0000));
        cyc(); expect_obs("clean_fill_2", e_fill(1'b0, 16'h1230, 1'b0, 16'h0001, 16'h0000));
        cyc(); pmem_resp = 1'b1;
        expect_obs("clean_fill_resp", e_fill(1'b0, 16'h1230, 1'b1, 16'h0001, 16'h0000));
        cyc(); pmem_resp = 1'b0; hit0 = 1'b1; valid0 = 1'b1;
        expect_obs("clean_complete", e_hit(1'b0, 1'b0, 16'h0001, 16'h0000));
        cyc(); drop_req();

        // Dirty miss: LRU[3]=1, way 1 dirty with tag 0x0AB -> writeback at 0x55B0.
        cyc(); mem_read = 1'b1; valid1 = 1'b1; dirty1 = 1'b1; tag1 = 9'h0AB;
        cyc(); expect_obs("dirty_wb_1", e_wb(1'b1, 16'h55B0, 16'h0002, 16'h0001));
        cyc(); pmem_resp = 1'b1;
        expect_obs("dirty_wb_resp", e_wb(1'b1, 16'h55B0, 16'h0002, 16'h0001));
        cyc(); pmem_resp = 1'b0;
        expect_obs("dirty_fill_1", e_fill(1'b1, 16'h1230, 1'b0, 16'h0002, 16'h0001));
        cyc(); pmem_resp = 1'b1;
        expect_obs("dirty_fill_resp", e_fill(1'b1, 16'h1230, 1'b1, 16'h0002, 16'h0001));
        cyc(); pmem_resp = 1'b0; dirty1 = 1'b0; hit1 = 1'b1;
        expect_obs("dirty_complete", e_hit(1'b1, 1'b0, 16'h0002, 16'h0001));
        cyc(); drop_req();

        // Write hit on way 0, then read+write together treated as a write (set 4, way 1).
        cyc(); mem_write = 1'b1; hit0 = 1'b1;
        expect_obs("write_hit", e_hit(1'b0, 1'b1, 16'h0002, 16'h0001));
        cyc(); drop_req();
        cyc(); mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h0040; hit1 = 1'b1;
        expect_obs("rw_both_write", e_hit(1'b1, 1'b1, 16'h0002, 16'h0001));
        cyc(); drop_req();

        // LRU from the write hit picks way 1; dirty way 0 must not force a writeback.
        cyc(); mem_read = 1'b1; mem_address = 16'h1234; valid0 = 1'b1; valid1 = 1'b1;
        dirty0 = 1'b1; dirty1 = 1'b0;
        cyc(); pmem_resp = 1'b1;
        expect_obs("lru_victim_fill", e_fill(1'b1, 16'h1230, 1'b1, 16'h0003, 16'h0001));
        cyc(); pmem_resp = 1'b0; hit1 = 1'b1;
        expect_obs("lru_complete", e_hit(1'b1, 1'b0, 16'h0003, 16'h0001));
        cyc(); drop_req(); dirty0 = 1'b0;

        // Make LRU[3]=1 so the post-reset victim shows the LRU clear.
        cyc(); mem_read = 1'b1; hit0 = 1'b1;
        expect_obs("pre_reset_hit", e_hit(1'b0, 1'b0, 16'h0003, 16'h0001));
        cyc(); drop_req();

        // Reset in the middle of a FILL; a stray pmem_resp afterwards is ignored.
        cyc(); mem_read = 1'b1; mem_address = 16'h2000; valid0 = 1'b0;
        cyc(); expect_obs("pre_reset_fill", e_fill(1'b0, 16'h2000, 1'b0, 16'h0004, 16'h0001));
        cyc(); rst_n = 1'b0; probe = 1'b1;
        expect_obs("reset_in_fill", e_zero(16'h0004, 16'h0001));
        cyc(); mem_read = 1'b0;
        expect_obs("reset_cleared", e_zero(16'h0000, 16'h0000));
        cyc(); rst_n = 1'b1; pmem_resp = 1'b1;
        expect_obs("post_reset_idle", e_zero(16'h0000, 16'h0000));
        cyc(); probe = 1'b0; pmem_resp = 1'b0;

        // Miss on set 3 after reset: LRU bits cleared, so victim is way 0.
        cyc(); mem_read = 1'b1; mem_address = 16'h1234; valid0 = 1'b0; valid1 = 1'b0;
        cyc(); pmem_resp = 1'b1;
        expect_obs("post_reset_fill", e_fill(1'b0, 16'h1230, 1'b1, 16'h0001, 16'h0000));
        cyc(); pmem_resp = 1'b0; hit0 = 1'b1;
        expect_obs("post_reset_complete", e_hit(1'b0, 1'b0, 16'h0001, 16'h0000));
        cyc(); drop_req();

        // Preload the miss counter just below the wrap point instead of 65536 real misses.
        force dut.miss_cnt_q = 16'hFFFE;
        cyc();
        release dut.miss_cnt_q;
        cyc(); mem_read = 1'b1;
        cyc(); pmem_resp = 1'b1;
        expect_obs("wrap_miss_ffff", e_fill(1'b1, 16'h1230, 1'b1, 16'hFFFF, 16'h0000));
        cyc(); pmem_resp = 1'b0;
        cyc(); pmem_resp = 1'b1;
        expect_obs("wrap_miss_0000", e_fill(1'b1, 16'h1230, 1'b1, 16'h0000, 16'h0000));
        cyc(); drop_req(); probe = 1'b1;
        expect_obs("wrap_idle", e_zero(16'h0000, 16'h0000));
        cyc(); probe = 1'b0;
        cyc();
        cyc();

        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
